avalon_pio_in_irq: RTL and testbench

Parametrised Avalon-MM input port for the Nios II system: samples a WIDTH-bit external input through a configurable synchroniser, latches per-bit edge events, and raises a maskable interrupt. It replaces the plain single-register input PIO wherever software needs event latching or interrupt-driven input. It sits on the Nios II data master interconnect as a read-latency-1 slave.

---
 rtl/avalon_pio_in_irq.sv | 102 ++++++++++
 tb/tb_avalon_pio_in_irq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_in_irq.sv
// Avalon-MM input port: synchronises an external bus, latches per-bit edge events
// and raises a maskable edge- or level-type interrupt. Read latency is one cycle.
module avalon_pio_in_irq #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_TYPE    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_s;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr_mask;
    logic             wr_en;
    logic             unused_wd;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r          = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // Synchroniser stages
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign data_s = in_port;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_p [SYNC_STAGES];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
                end else begin
                    sync_p[0] <= in_port;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
                end
            end
            assign data_s = sync_p[SYNC_STAGES-1];
        end
    endgenerate

    assign wr_en     = chipselect && !write_n;
    assign unused_wd = ^writedata;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_det = data_s & ~prev;
            1:       edge_det = ~data_s & prev;
            default: edge_det = data_s ^ prev;
        endcase
    end

    assign clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Edge/capture/mask registers; a coincident new edge overrides the W1C clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev        <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            prev        <= data_s;
            edgecapture <= (edgecapture & ~clr_mask) | edge_det;
            if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Registered read mux, updated every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= zext(data_s);
                2'd2:    readdata <= zext(irqmask);
                2'd3:    readdata <= zext(edgecapture);
                default: readdata <= '0;
            endcase
        end
    end

    generate
        if (IRQ_TYPE == 1) begin : g_level_irq
            assign irq = |(data_s & irqmask);
        end else begin : g_edge_irq
            assign irq = |(edgecapture & irqmask);
        end
    endgenerate

endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// Bench for avalon_pio_in_irq: three parameterisations driven from a shared bus,
// directed steps followed by random traffic, all checked against a register-level model.
module tb_avalon_pio_in_irq;

    localparam int NI = 3;
    localparam int SYNC [NI] = '{2, 0, 1};
    localparam int EDGE [NI] = '{0, 2, 1};
    localparam int IRQT [NI] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  inp  [NI];
    logic [31:0] rd   [NI];
    logic        irqs [NI];

    int errors = 0;
    int checks = 0;

    // Reference state per instance
    logic [7:0] hist  [NI][3];
    logic [7:0] mprev [NI];
    logic [7:0] mmask [NI];
    logic [7:0] mecap [NI];
    logic [7:0] mrd   [NI];

    always #5 clk = ~clk;

    avalon_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[0]), .in_port(inp[0]), .irq(irqs[0]));

    avalon_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(0), .EDGE_TYPE(2), .IRQ_TYPE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[1]), .in_port(inp[1]), .irq(irqs[1]));

    avalon_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(1), .EDGE_TYPE(1), .IRQ_TYPE(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd[2]), .in_port(inp[2]), .irq(irqs[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value seen by the port logic: the input sampled SYNC edges ago
    function automatic logic [7:0] data_now(input int k);
        if (SYNC[k] == 0) return inp[k];
        return hist[k][SYNC[k]-1];
    endfunction

    function automatic logic exp_irq(input int k);
        if (IRQT[k] == 1) return |(data_now(k) & mmask[k]);
        return |(mecap[k] & mmask[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 3; j++) hist[k][j] = 8'h00;
            mprev[k] = 8'h00; mmask[k] = 8'h00; mecap[k] = 8'h00; mrd[k] = 8'h00;
        end
    endtask

    // One clock: compute next state from pre-edge inputs, then compare at the falling edge
    task automatic cycle();
        logic [7:0] ds, ev, clr;
        logic [7:0] n_rd [NI];
        logic [7:0] n_ecap [NI];
        logic [7:0] n_mask [NI];
        logic [7:0] n_prev [NI];
        logic       wr;
        wr  = chipselect && !write_n;
        clr = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
        for (int k = 0; k < NI; k++) begin
            ds = data_now(k);
            case (EDGE[k])
                0:       ev = ds & ~mprev[k];
                1:       ev = ~ds & mprev[k];
                default: ev = ds ^ mprev[k];
            endcase
            n_ecap[k] = (mecap[k] & ~clr) | ev;
            n_mask[k] = (wr && address == 2'd2) ? writedata[7:0] : mmask[k];
            n_prev[k] = ds;
            case (address)
                2'd0:    n_rd[k] = ds;
                2'd2:    n_rd[k] = mmask[k];
                2'd3:    n_rd[k] = mecap[k];
                default: n_rd[k] = 8'h00;
            endcase
        end
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < NI; k++) begin
                mecap[k] = n_ecap[k]; mmask[k] = n_mask[k];
                mprev[k] = n_prev[k]; mrd[k]   = n_rd[k];
                hist[k][2] = hist[k][1]; hist[k][1] = hist[k][0]; hist[k][0] = inp[k];
            end
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("model_rd%0d", k), rd[k], {24'h0, mrd[k]});
            chk($sformatf("model_irq%0d", k), {31'h0, irqs[k]}, {31'h0, exp_irq(k)});
        end
    endtask

    task automatic wr_op(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_op(input logic [1:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        cycle();
        chipselect = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        for (int k = 0; k < NI; k++) inp[k] = 8'hA5;
        model_reset();
        cycle(); cycle();
        chk("reset_irq_a", {31'h0, irqs[0]}, 32'h0);
        chk("reset_rd_a", rd[0], 32'h0);
        reset_n = 1'b1;
        repeat (4) cycle();

        // Reset and read
        rd_op(2'd0); chk("data_a5", rd[0], 32'h0000_00A5); chk("data_a5_b", rd[1], 32'h0000_00A5);
        rd_op(2'd1); chk("reserved", rd[0], 32'h0);
        rd_op(2'd2); chk("mask_reset", rd[0], 32'h0);
        rd_op(2'd3); chk("post_reset_rise", rd[0], 32'h0000_00A5);
        chk("no_irq_unmasked", {31'h0, irqs[0]}, 32'h0);
        for (int k = 0; k < NI; k++) inp[k] = 8'h00;
        repeat (4) cycle();
        wr_op(2'd3, 32'hFFFF_FFFF);
        rd_op(2'd3); chk("ecap_cleared", rd[0], 32'h0);

        // Rising capture and IRQ
        wr_op(2'd2, 32'h01);
        inp[0] = 8'h01;
        cycle(); cycle();
        chk("irq_before_3", {31'h0, irqs[0]}, 32'h0);
        cycle();
        chk("irq_at_3", {31'h0, irqs[0]}, 32'h1);
        rd_op(2'd3); chk("ecap_bit0", rd[0], 32'h01);
        wr_op(2'd3, 32'h01);
        chk("irq_w1c", {31'h0, irqs[0]}, 32'h0);
        rd_op(2'd3); chk("ecap_w1c", rd[0], 32'h0);

        // Masking
        wr_op(2'd2, 32'h00);
        inp[0] = 8'h09;
        repeat (3) cycle();
        chk("masked_irq", {31'h0, irqs[0]}, 32'h0);
        rd_op(2'd3); chk("masked_ecap", rd[0], 32'h08);
        wr_op(2'd2, 32'h08);
        chk("unmask_irq", {31'h0, irqs[0]}, 32'h1);

        // Set beats clear on bit2 (already set, new edge lands with the W1C)
        inp[0] = 8'h0D; repeat (3) cycle();
        inp[0] = 8'h09; repeat (3) cycle();
        inp[0] = 8'h0D; cycle(); cycle();
        wr_op(2'd3, 32'h04);
        rd_op(2'd3); chk("set_beats_clear", rd[0], 32'h0C);
        wr_op(2'd3, 32'h04);
        rd_op(2'd3); chk("plain_clear", rd[0], 32'h08);

        // Any-edge capture
        wr_op(2'd3, 32'hFF);
        inp[1] = 8'h0F; cycle(); cycle();
        wr_op(2'd3, 32'hFF);
        inp[1] = 8'hF0; cycle();
        rd_op(2'd3); chk("any_edge", rd[1], 32'hFF);

        // Level interrupt follows data
        wr_op(2'd2, 32'h80);
        inp[1] = 8'h00; cycle();
        chk("level_low0", {31'h0, irqs[1]}, 32'h0);
        inp[1] = 8'h80; #1;
        chk("level_high_comb", {31'h0, irqs[1]}, 32'h1);
        cycle();
        chk("level_high", {31'h0, irqs[1]}, 32'h1);
        inp[1] = 8'h00; #1;
        chk("level_low_comb", {31'h0, irqs[1]}, 32'h0);
        cycle();

        // Reset mid-operation
        inp[0] = 8'h00; repeat (3) cycle();
        wr_op(2'd3, 32'hFF);
        wr_op(2'd2, 32'hFF);
        inp[0] = 8'h3C; repeat (3) cycle();
        chk("pre_reset_irq", {31'h0, irqs[0]}, 32'h1);
        rd_op(2'd3); chk("pre_reset_ecap", rd[0], 32'h3C);
        for (int k = 0; k < NI; k++) inp[k] = 8'h00;
        #2 reset_n = 1'b0;
        #1;
        chk("async_irq_drop", {31'h0, irqs[0]}, 32'h0);
        chk("async_rd_clear", rd[0], 32'h0);
        model_reset();
        #1 reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_op(a[1:0]);
            chk($sformatf("post_reset_reg%0d", a), rd[0], 32'h0);
        end
        inp[1] = 8'h5A;
        rd_op(2'd0); chk("nosync_latency", rd[1], 32'h5A);

        // Random traffic against the model
        repeat (400) begin
            for (int k = 0; k < NI; k++)
                if ($urandom_range(3) == 0) inp[k] = 8'($urandom);
            address    = 2'($urandom);
            chipselect = 1'($urandom);
            write_n    = 1'($urandom);
            writedata  = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
